// File: rtl/wr_ctrl_if.sv
// Producer / buffer-write / slot-status bundle for the ping-pong write controller.
// Ports (master = wr_ctrl view):
//   din, din_vld      producer byte and strobe (in)
//   din_rdy, din_err  accept-ready and dropped-byte pulse (out)
//   r_done            one-hot slot release from the read controller (in)
//   w_en, w_addr, w_data  buffer write port (out)
//   status_vld        per-slot "holds unread data" flags (out)
//   err_cnt           saturating count of dropped bytes (out)
interface wr_ctrl_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned ECW = 8
);
  logic [DW-1:0]  din;
  logic           din_vld;
  logic           din_rdy;
  logic           din_err;
  logic [1:0]     r_done;
  logic           w_en;
  logic           w_addr;
  logic [DW-1:0]  w_data;
  logic [1:0]     status_vld;
  logic [ECW-1:0] err_cnt;

  modport master (
    input  din, din_vld, r_done,
    output din_rdy, din_err, w_en, w_addr, w_data, status_vld, err_cnt
  );

  modport slave (
    output din, din_vld, r_done,
    input  din_rdy, din_err, w_en, w_addr, w_data, status_vld, err_cnt
  );
endinterface

// File: rtl/wr_ctrl.sv
// Write-side controller for a 2-entry ping-pong byte buffer.
// Accepts producer bytes (valid/ready), writes them alternately to slot 0/1,
// owns the per-slot valid flags released by the read controller via r_done,
// and flags/counts bytes offered while the target slot is still full.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  wr_ctrl_if.master (producer handshake, buffer write port, status)
module wr_ctrl #(
  parameter int unsigned DW  = 8,
  parameter int unsigned ECW = 8
) (
  input  logic       clk,
  input  logic       rst,
  wr_ctrl_if.master  bus
);

  localparam int unsigned SLOTS = 2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               take;
  logic [SLOTS-1:0]   set_mask;
  logic [SLOTS-1:0]   status_next;

  logic               din_rdy_q;
  logic               din_err_q;
  logic               w_en_q;
  logic               w_addr_q;
  logic [DW-1:0]      w_data_q;
  logic [SLOTS-1:0]   status_q;
  logic [ECW-1:0]     err_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Next-state, capture strobe and flag update
  always_comb begin
    next_state  = state;
    take        = 1'b0;
    set_mask    = '0;
    case (state)
      INIT: next_state = IDLE;
      IDLE: begin
        if (bus.din_vld) begin
          if (status_q[w_addr_q]) begin
            next_state = ERR;
          end else begin
            next_state = WR;
            take       = 1'b1;
          end
        end
      end
      WR: begin
        next_state = IDLE;
        set_mask   = w_addr_q ? 2'b10 : 2'b01;
      end
      ERR:     next_state = IDLE;
      default: next_state = INIT;
    endcase
    // Set has priority over a same-cycle release of the same slot
    status_next = (status_q & ~bus.r_done) | set_mask;
  end

  // Datapath and registered outputs; strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      din_rdy_q <= 1'b0;
      din_err_q <= 1'b0;
      w_en_q    <= 1'b0;
      w_addr_q  <= 1'b0;
      w_data_q  <= '0;
      status_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      din_rdy_q <= (next_state == IDLE);
      din_err_q <= (next_state == ERR);
      w_en_q    <= (next_state == WR);
      status_q  <= status_next;
      if (take)
        w_data_q <= bus.din;
      // Slot pointer only advances on a completed write, so drops keep order
      if (state == WR)
        w_addr_q <= ~w_addr_q;
      if ((state == ERR) && (err_cnt_q != {ECW{1'b1}}))
        err_cnt_q <= err_cnt_q + ECW'(1);
    end
  end

  assign bus.din_rdy    = din_rdy_q;
  assign bus.din_err    = din_err_q;
  assign bus.w_en       = w_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign bus.status_vld = status_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_wr_ctrl.sv
// Self-checking bench for wr_ctrl: scoreboard of expected buffer writes and
// expected drops, plus a small reference model of flags, pointer and counter.
module tb_wr_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned ECW = 8;

  logic clk = 1'b0;
  logic rst;

  wr_ctrl_if #(.DW(DW), .ECW(ECW)) bus ();

  wr_ctrl #(.DW(DW), .ECW(ECW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW:0]    exp_wr[$];
  logic [ECW-1:0] exp_err[$];

  logic [1:0]     m_st;
  logic           m_addr;
  logic [ECW-1:0] m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every write/drop the DUT produces must match the queue head
  always @(negedge clk) begin : mon
    logic [DW:0]    e_wr;
    logic [ECW-1:0] e_er;
    if (bus.w_en === 1'b1) begin
      if (exp_wr.size() == 0) check("spurious_wr", 32'd1, 32'd0);
      else begin
        e_wr = exp_wr.pop_front();
        check("wr_addr", 32'(bus.w_addr), 32'(e_wr[DW]));
        check("wr_data", 32'(bus.w_data), 32'(e_wr[DW-1:0]));
      end
    end
    if (bus.din_err === 1'b1) begin
      if (exp_err.size() == 0) check("spurious_err", 32'd1, 32'd0);
      else begin
        e_er = exp_err.pop_front();
        check("err_no_wen", 32'(bus.w_en), 32'd0);
        check("err_cnt_pre", 32'(bus.err_cnt), 32'(e_er));
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_status"}, 32'(bus.status_vld), 32'(m_st));
    check({tag, "_addr"},   32'(bus.w_addr),     32'(m_addr));
    check({tag, "_errcnt"}, 32'(bus.err_cnt),    32'(m_err));
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.din      = '0;
    bus.din_vld  = 1'b0;
    bus.r_done   = 2'b00;
    tick();
    tick();
    m_st   = 2'b00;
    m_addr = 1'b0;
    m_err  = '0;
    check("rst_rdy",   32'(bus.din_rdy), 32'd0);
    check("rst_wen",   32'(bus.w_en),    32'd0);
    check("rst_derr",  32'(bus.din_err), 32'd0);
    check("rst_wdata", 32'(bus.w_data),  32'd0);
    check_state("rst");
    rst = 1'b0;
    check("init_rdy", 32'(bus.din_rdy), 32'd0);
    tick();
    check("idle_rdy", 32'(bus.din_rdy), 32'd1);
    check_state("idle");
  endtask

  // Offer one byte; rd is driven on r_done during the cycle after acceptance
  task automatic send(input logic [DW-1:0] data, input logic [1:0] rd);
    int n;
    bit wr;
    n = 0;
    while (bus.din_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.din_rdy !== 1'b1) begin
      check("rdy_timeout", 32'd0, 32'd1);
      return;
    end
    wr = (m_st[m_addr] == 1'b0);
    if (wr) exp_wr.push_back({m_addr, data});
    else    exp_err.push_back(m_err);
    bus.din     = data;
    bus.din_vld = 1'b1;
    tick();
    if (wr) check("wr_wen", 32'(bus.w_en), 32'd1);
    else    check("err_pulse", 32'(bus.din_err), 32'd1);
    check("busy_rdy", 32'(bus.din_rdy), 32'd0);
    // Garbage held valid while not ready must be ignored
    bus.din    = ~data;
    bus.r_done = rd;
    tick();
    bus.din_vld = 1'b0;
    bus.r_done  = 2'b00;
    if (wr) begin
      m_st   = (m_st & ~rd) | (m_addr ? 2'b10 : 2'b01);
      m_addr = ~m_addr;
      check("hold_wdata", 32'(bus.w_data), 32'(data));
    end else begin
      m_st = m_st & ~rd;
      if (m_err != {ECW{1'b1}}) m_err = m_err + ECW'(1);
    end
    check("post_rdy",  32'(bus.din_rdy), 32'd1);
    check("post_wen",  32'(bus.w_en),    32'd0);
    check("post_derr", 32'(bus.din_err), 32'd0);
    check_state("post");
  endtask

  task automatic rdone_pulse(input logic [1:0] rd);
    bus.r_done = rd;
    tick();
    bus.r_done = 2'b00;
    m_st = m_st & ~rd;
    check_state("rel");
  endtask

  initial begin
    rst         = 1'b1;
    bus.din     = '0;
    bus.din_vld = 1'b0;
    bus.r_done  = 2'b00;
    do_reset();

    // Single write into slot 0
    send(8'hA5, 2'b00);
    check("single_status", 32'(bus.status_vld), 32'h1);

    // Fill both slots, then overflow
    do_reset();
    send(8'h11, 2'b00);
    send(8'h22, 2'b00);
    check("full_status", 32'(bus.status_vld), 32'h3);
    send(8'h33, 2'b00);
    check("ovf_errcnt", 32'(bus.err_cnt), 32'd1);
    check("ovf_addr",   32'(bus.w_addr),  32'd0);

    // Release slot 0 and resume
    rdone_pulse(2'b01);
    check("rel_10", 32'(bus.status_vld), 32'h2);
    send(8'h44, 2'b00);
    check("resume_11", 32'(bus.status_vld), 32'h3);

    // Dual release, then release of an already-empty slot
    rdone_pulse(2'b11);
    rdone_pulse(2'b01);

    // Concurrent release of slot 1 while slot 0 is being written
    send(8'h50, 2'b00);
    check("pre_conc", 32'(bus.status_vld), 32'h2);
    send(8'h55, 2'b10);
    check("conc_01", 32'(bus.status_vld), 32'h1);

    // Refill and drive the error counter into saturation
    send(8'h60, 2'b00);
    for (int i = 0; i < 260; i++) send(DW'(i), 2'b00);
    check("err_sat", 32'(bus.err_cnt), 32'hFF);

    // Reset in the middle of a write
    rdone_pulse(2'b11);
    exp_wr.push_back({m_addr, 8'h66});
    bus.din     = 8'h66;
    bus.din_vld = 1'b1;
    tick();
    check("mid_wen", 32'(bus.w_en), 32'd1);
    rst         = 1'b1;
    bus.din_vld = 1'b0;
    tick();
    check("midrst_status", 32'(bus.status_vld), 32'h0);
    check("midrst_wen",    32'(bus.w_en),       32'd0);
    check("midrst_rdy",    32'(bus.din_rdy),    32'd0);
    do_reset();

    tick();
    check("sb_wr_empty",  32'(exp_wr.size()),  32'd0);
    check("sb_err_empty", 32'(exp_err.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
